// File: rtl/power_activity_gen.sv
// Switching-activity generator: NCH channels stepping as hold/counter/LFSR/toggle
// at a prescaled rate, with optional bounded bursts and a one-cycle done pulse.
module power_activity_gen #(
  parameter int              WIDTH   = 8,
  parameter int              NCH     = 4,
  parameter int              DIV_W   = 8,
  parameter int              BURST_W = 16,
  parameter logic [WIDTH-1:0] POLY   = WIDTH'(8'hB8)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_we,
  input  logic [1:0]           cfg_mode,
  input  logic [DIV_W-1:0]     cfg_div,
  input  logic [BURST_W-1:0]   cfg_burst,
  input  logic [NCH-1:0]       cfg_mask,
  input  logic                 start,
  input  logic                 stop,
  output logic [NCH*WIDTH-1:0] ch_out,
  output logic                 busy,
  output logic                 done,
  output logic [BURST_W-1:0]   step_cnt
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q;
  logic [1:0]         mode_q;
  logic [DIV_W-1:0]   div_q;
  logic [BURST_W-1:0] burst_q;
  logic [NCH-1:0]     mask_q;
  logic [DIV_W-1:0]   pre_q;
  logic [BURST_W-1:0] step_q;
  logic               done_q;
  logic [WIDTH-1:0]   ch_q [NCH];

  logic [1:0]         eff_mode;
  logic [NCH-1:0]     eff_mask;
  logic [BURST_W-1:0] step_d;
  logic               step_now;

  // A config write on the start edge takes effect for that very run.
  assign eff_mode = cfg_we ? cfg_mode : mode_q;
  assign eff_mask = cfg_we ? cfg_mask : mask_q;
  assign step_d   = step_q + BURST_W'(1);
  assign step_now = (pre_q == div_q);

  function automatic logic [WIDTH-1:0] seed_val(input logic [1:0] mode, input int idx,
                                                input logic [WIDTH-1:0] cur);
    logic [WIDTH-1:0] r;
    case (mode)
      2'd1:    r = WIDTH'(idx);
      2'd2:    r = WIDTH'(idx + 1);
      2'd3:    r = {(WIDTH/2){2'b01}};
      default: r = cur;
    endcase
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] step_val(input logic [1:0] mode, input logic [WIDTH-1:0] cur);
    logic [WIDTH-1:0] r;
    case (mode)
      2'd1:    r = cur + WIDTH'(1);
      2'd2:    r = (cur >> 1) ^ (cur[0] ? POLY : '0);
      2'd3:    r = ~cur;
      default: r = cur;
    endcase
    return r;
  endfunction

  // start/stop are level-sampled commands: start acts only in IDLE without stop,
  // stop acts only in RUN; neither is acknowledged beyond the busy level.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= 2'd0;
      div_q   <= '0;
      burst_q <= '0;
      mask_q  <= '1;
      pre_q   <= '0;
      step_q  <= '0;
      done_q  <= 1'b0;
      for (int c = 0; c < NCH; c++) ch_q[c] <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cfg_we) begin
            mode_q  <= cfg_mode;
            div_q   <= cfg_div;
            burst_q <= cfg_burst;
            mask_q  <= cfg_mask;
          end
          if (start && !stop) begin
            state_q <= RUN;
            pre_q   <= '0;
            step_q  <= '0;
            for (int c = 0; c < NCH; c++)
              ch_q[c] <= eff_mask[c] ? seed_val(eff_mode, c, ch_q[c]) : '0;
          end
        end
        RUN: begin
          if (step_now) begin
            pre_q  <= '0;
            step_q <= step_d;
            for (int c = 0; c < NCH; c++)
              if (mask_q[c]) ch_q[c] <= step_val(mode_q, ch_q[c]);
          end else begin
            pre_q <= pre_q + DIV_W'(1);
          end
          // Stop outranks burst completion, but the coincident step still lands.
          if (stop) begin
            state_q <= IDLE;
          end else if (step_now && burst_q != '0 && step_d == burst_q) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    assign ch_out[g*WIDTH +: WIDTH] = ch_q[g];
  end

  assign busy     = (state_q == RUN);
  assign done     = done_q;
  assign step_cnt = step_q;

endmodule

// File: doc/power_activity_gen.md
Name: power_activity_gen

Overview:
- Parametrised switching-activity generator for silicon power characterisation; successor to the single 8-bit free-running power-test counter.
- Drives NCH independent WIDTH-bit channels, each in a selectable pattern mode: hold, counter, LFSR or full toggle.
- Adds a programmable step prescaler (activity throttle), a per-channel enable mask, and bounded bursts with a done pulse.
- Sits between the tile pad wrapper and the output muxes; the wrapper maps ch_out onto pads.

Parameters:
- WIDTH, 8, bits per channel; even, ≥4.
- NCH, 4, number of channels.
- DIV_W, 8, prescaler width.
- BURST_W, 16, burst/step counter width.
- POLY, 8'hB8, Galois LFSR feedback taps (WIDTH bits).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- cfg_we  in  1  config write strobe.
- cfg_mode  in  2  0=hold, 1=counter, 2=LFSR, 3=toggle.
- cfg_div  in  DIV_W  step every cfg_div+1 cycles.
- cfg_burst  in  BURST_W  steps per burst; 0=free-run.
- cfg_mask  in  NCH  channel enable, 1=active.
- start  in  1  begin run.
- stop  in  1  abort run.
- ch_out  out  NCH*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH].
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse at burst completion.
- step_cnt  out  BURST_W  steps taken this run.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (rst high at an edge):
  - state=IDLE; ch_out, busy, done, step_cnt, prescaler all 0.
  - Config resets to mode=0, div=0, burst=0, mask=all-ones.
  - Reset mid-run has the same effect; no done pulse.
- Config:
  - cfg_we in IDLE latches mode/div/burst/mask at the edge.
  - cfg_we while busy is ignored entirely.
  - cfg_we together with start in IDLE: the new config applies to that run.
- States: IDLE, RUN. done is a registered pulse, not a state.
- Start (IDLE, start=1, stop=0 at edge E0). After E0:
  - busy=1, pre=0, step_cnt=0.
  - Each active channel loads its seed:
    - counter: c.
    - LFSR: c+1 (never 0).
    - toggle: alternating bits, LSB=1 (0x55 for WIDTH=8).
    - hold: the channel keeps its current value.
  - start while busy is ignored. start and stop together in IDLE: no action.
- Prescaler in RUN:
  - Each edge: if pre==div, step and set pre=0; else pre=pre+1.
  - div=0 steps every cycle; the first step is at E1.
- Step, per active channel:
  - counter: +1 mod 2^WIDTH.
  - LFSR: r = (r>>1) ^ (r[0] ? POLY : 0).
  - toggle: r = ~r.
  - hold: unchanged.
  - step_cnt increments on every step, wrapping mod 2^BURST_W in free-run.
- Masked channel (mask bit 0): register forced to 0 at start and held there; zero switching activity.
- Burst end (burst≠0): on the edge where a step makes step_cnt==burst:
  - state becomes IDLE, busy=0, done=1 for exactly one cycle.
  - Channels and step_cnt hold their final values.
- Stop in RUN: state becomes IDLE at that edge, busy=0, no done. Channels and step_cnt hold.
  - If stop and the final burst step coincide, stop wins: no done.
  - The step itself still applies.
- Outputs: ch_out and step_cnt are registered and hold in IDLE until the next start or reset.

Test Plan:
- Reset, then idle 10 cycles: ch_out=0, busy=0, done=0, step_cnt=0. Reset with all inputs X-free: outputs stay 0.
- Counter mode, div=0, burst=4, mask=4'hF, start:
  - ch_out channels = {3,2,1,0} after E0, {7,6,5,4} after E4.
  - done high exactly the cycle after E4; busy low; step_cnt=4; values hold 5 cycles.
- LFSR mode, div=2, burst=3:
  - channel0 goes 0x01 → 0xB8 → 0x5C → 0x2E.
  - Steps at E3, E6, E9; channel1 seed 0x02 steps to 0x01.
- Toggle mode, div=0, burst=0, mask=4'b0101:
  - ch0/ch2 alternate 0x55/0xAA every cycle; ch1/ch3 stay 0.
  - stop after 6 cycles: busy drops, no done, values frozen.
- cfg_we with div=5 during a div=0 run: ignored, run continues at one step per cycle. After stop, a new cfg_we/start uses div=5.
- rst asserted for one cycle mid-burst (step_cnt=2, burst=10): next cycle all outputs 0, IDLE, config defaults, no done pulse.
